// File: rtl/imem_loader_pkg.sv
// Shared types and sizing helpers for the instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

    localparam int DATAWIDTH_DEF  = 32;
    localparam int BYTES_PER_WORD = DATAWIDTH_DEF / 8;

    // Bytes per word for an arbitrary word width (width is a multiple of 8).
    function automatic int bytes_per_word(input int dw);
        return dw / 8;
    endfunction

    // Index/address width that never collapses to zero bits.
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the loader.
// Signal suffixes are from the loader's point of view.
interface imem_loader_if #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRW     = 5
);
    logic                 byte_valid_i;
    logic [7:0]           byte_i;
    logic                 byte_ready_o;
    logic                 mem_we_o;
    logic [ADDRW-1:0]     mem_waddr_o;
    logic [DATAWIDTH-1:0] mem_wdata_o;

    // Loader side: consumes the stream, drives the memory write port.
    modport master (
        input  byte_valid_i, byte_i,
        output byte_ready_o, mem_we_o, mem_waddr_o, mem_wdata_o
    );

    // Host/memory side.
    modport slave (
        output byte_valid_i, byte_i,
        input  byte_ready_o, mem_we_o, mem_waddr_o, mem_wdata_o
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-lane assembler: shifts accepted bytes into lanes and
// flags the byte that completes a word. word_o already contains the byte
// currently being accepted, so the caller can capture a full word in the
// same cycle the strobe is high.
module loader_word_assembler
    import loader_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 byte_we_i,
    input  logic [7:0]           byte_i,
    output logic [DATAWIDTH-1:0] word_o,
    output logic                 word_done_o
);
    localparam int BPW  = bytes_per_word(DATAWIDTH);
    localparam int IDXW = addr_width(BPW);

    logic [IDXW-1:0]      idx_q;
    logic [DATAWIDTH-1:0] word_q;

    // Current word with the incoming byte merged into its lane.
    always_comb begin
        word_o = word_q;
        for (int l = 0; l < BPW; l++) begin
            if (idx_q == IDXW'(l)) word_o[l*8 +: 8] = byte_i;
        end
        word_done_o = byte_we_i && (idx_q == IDXW'(BPW - 1));
    end

    // Lane storage and byte index; index wraps after the last lane.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (clr_i) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (byte_we_i) begin
            word_q <= word_o;
            idx_q  <= word_done_o ? '0 : idx_q + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed image into imem and keeps the
// core in reset until the whole image has been written and verified.
// Stream format: N, then N little-endian words, then XOR of all data bytes.
module imem_loader
    import loader_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int NUMWORDS  = 32,
    parameter int ADDRW     = addr_width(NUMWORDS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    imem_loader_if.master bus,
    output logic          cpu_rst_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o
);
    loader_state_t        state_q, state_d;
    logic [7:0]           n_q;
    logic [ADDRW-1:0]     word_cnt_q;
    logic [7:0]           csum_q;
    logic                 mem_we_q;
    logic [ADDRW-1:0]     mem_waddr_q;
    logic [DATAWIDTH-1:0] mem_wdata_q;

    logic                 byte_ready;
    logic                 accept;
    logic                 start_load;
    logic                 data_acc;
    logic                 last_word;
    logic                 word_done;
    logic [DATAWIDTH-1:0] word_full;

    assign accept     = bus.byte_valid_i && byte_ready;
    assign start_load = start_i && (state_q inside {IDLE, DONE, ERROR});
    assign data_acc   = accept && (state_q == DATA);
    assign last_word  = (8'(word_cnt_q) == (n_q - 8'd1));

    loader_word_assembler #(.DATAWIDTH(DATAWIDTH)) u_asm (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (start_load),
        .byte_we_i   (data_acc),
        .byte_i      (bus.byte_i),
        .word_o      (word_full),
        .word_done_o (word_done)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: length byte, data words, checksum byte, then verdict.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERROR: if (start_i) state_d = COUNT;
            COUNT: begin
                if (accept) begin
                    if (bus.byte_i == 8'd0 || bus.byte_i > 8'(NUMWORDS)) state_d = ERROR;
                    else                                                 state_d = DATA;
                end
            end
            DATA:    if (word_done && last_word) state_d = CSUM;
            CSUM:    if (accept) state_d = (bus.byte_i == csum_q) ? DONE : ERROR;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        byte_ready = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        error_o    = 1'b0;
        cpu_rst_o  = 1'b1;
        case (state_q)
            COUNT, DATA, CSUM: begin
                byte_ready = 1'b1;
                busy_o     = 1'b1;
            end
            DONE:    begin done_o = 1'b1; cpu_rst_o = 1'b0; end
            ERROR:   error_o = 1'b1;
            default: ;
        endcase
    end

    // Counters, checksum and the registered imem write port. The write
    // registers are separate from lane storage so the next word can start
    // filling while the previous one is being written.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            n_q         <= '0;
            word_cnt_q  <= '0;
            csum_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= word_done;
            if (start_load) begin
                n_q        <= '0;
                word_cnt_q <= '0;
                csum_q     <= '0;
            end else begin
                if (accept && state_q == COUNT) n_q <= bus.byte_i;
                if (data_acc) csum_q <= csum_q ^ bus.byte_i;
                if (word_done) begin
                    mem_waddr_q <= word_cnt_q;
                    mem_wdata_q <= word_full;
                    word_cnt_q  <= word_cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.byte_ready_o = byte_ready;
    assign bus.mem_we_o     = mem_we_q;
    assign bus.mem_waddr_o  = mem_waddr_q;
    assign bus.mem_wdata_o  = mem_wdata_q;

endmodule
